// File: rtl/life_double_buffer.sv
// rtl/life_double_buffer.sv - double-buffered board memory and generation sequencer for life_logic
//
// Holds two board banks. The front bank (bank_sel_out) serves life_logic's
// read port and the display read port; the back bank absorbs life_logic's
// word writes. Generations are started on a frame sync and banks are only
// swapped on a frame sync, so the display never shows a half-written board.
//
// Optional build macro: LIFE_DB_CLEAR_EN
//   defined   - after reset both banks are swept to zero, busy_out high meanwhile
//   undefined - no sweep, busy_out tied 0, power-up memory contents unspecified
//
// Ports:
//   clk_in            system clock
//   rst_n_in          asynchronous active-low reset
//   frame_sync_in     one-cycle pulse at display vertical blank
//   logic_addr_r_in   life_logic read address (front bank)
//   logic_data_r_out  life_logic read data, 2-cycle latency
//   logic_addr_w_in   life_logic write address (back bank)
//   logic_data_w_in   life_logic write data
//   logic_wr_en_in    life_logic write strobe
//   logic_done_in     life_logic done level
//   logic_start_out   one-cycle start pulse to life_logic
//   disp_addr_in      display read address (front bank)
//   disp_data_out     display read data, 2-cycle latency
//   bank_sel_out      current front bank index
//   frame_skip_out    saturating count of frame syncs missed while computing
//   busy_out          high while the post-reset clear sweep runs

module life_double_buffer #(
  parameter int WORD_SIZE    = 16,
  parameter int LOG_MAX_ADDR = 12,
  parameter int MAX_ADDR     = 4096,
  parameter int DONE_MASK    = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    frame_sync_in,
  input  logic [LOG_MAX_ADDR-1:0] logic_addr_r_in,
  output logic [WORD_SIZE-1:0]    logic_data_r_out,
  input  logic [LOG_MAX_ADDR-1:0] logic_addr_w_in,
  input  logic [WORD_SIZE-1:0]    logic_data_w_in,
  input  logic                    logic_wr_en_in,
  input  logic                    logic_done_in,
  output logic                    logic_start_out,
  input  logic [LOG_MAX_ADDR-1:0] disp_addr_in,
  output logic [WORD_SIZE-1:0]    disp_data_out,
  output logic                    bank_sel_out,
  output logic [7:0]              frame_skip_out,
  output logic                    busy_out
);

  localparam int MASK_W = (DONE_MASK > 1) ? $clog2(DONE_MASK) : 1;
  localparam logic [MASK_W-1:0] MASK_INIT = MASK_W'(DONE_MASK - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MASK,
    S_RUN,
    S_READY
`ifdef LIFE_DB_CLEAR_EN
    ,
    S_CLEAR
`endif
  } state_t;

  // Board storage; never reset, only written.
  logic [WORD_SIZE-1:0] bank0 [MAX_ADDR];
  logic [WORD_SIZE-1:0] bank1 [MAX_ADDR];

  state_t            state_q, state_next;
  logic [MASK_W-1:0] mask_cnt_q, mask_cnt_next;
  logic              bank_sel_q, bank_sel_next;
  logic              start_q, start_next;
  logic [7:0]        skip_q, skip_next;

`ifdef LIFE_DB_CLEAR_EN
  localparam logic [LOG_MAX_ADDR-1:0] LAST_ADDR = LOG_MAX_ADDR'(MAX_ADDR - 1);
  logic                    clear_pending_q, clear_pending_next;
  logic [LOG_MAX_ADDR-1:0] clr_addr_q, clr_addr_next;
`endif

  logic [LOG_MAX_ADDR-1:0] logic_addr_q;
  logic [LOG_MAX_ADDR-1:0] disp_addr_q;
  logic [WORD_SIZE-1:0]    logic_rd_word;
  logic [WORD_SIZE-1:0]    disp_rd_word;
  logic                    rd_zero;

  logic                    wr0_en, wr1_en;
  logic [LOG_MAX_ADDR-1:0] wr_addr;
  logic [WORD_SIZE-1:0]    wr_data;

  // Skip counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---------------------------------------------------------------------
  // Sequencer state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      mask_cnt_q <= '0;
      bank_sel_q <= 1'b0;
      start_q    <= 1'b0;
      skip_q     <= 8'd0;
`ifdef LIFE_DB_CLEAR_EN
      clear_pending_q <= 1'b1;
      clr_addr_q      <= '0;
`endif
    end else begin
      state_q    <= state_next;
      mask_cnt_q <= mask_cnt_next;
      bank_sel_q <= bank_sel_next;
      start_q    <= start_next;
      skip_q     <= skip_next;
`ifdef LIFE_DB_CLEAR_EN
      clear_pending_q <= clear_pending_next;
      clr_addr_q      <= clr_addr_next;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state_q;
    mask_cnt_next = mask_cnt_q;
    bank_sel_next = bank_sel_q;
    start_next    = 1'b0;
    skip_next     = skip_q;
`ifdef LIFE_DB_CLEAR_EN
    clear_pending_next = clear_pending_q;
    clr_addr_next      = clr_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef LIFE_DB_CLEAR_EN
        // The sweep takes priority over a sync arriving right after reset.
        if (clear_pending_q) begin
          clear_pending_next = 1'b0;
          clr_addr_next      = '0;
          state_next         = S_CLEAR;
        end else
`endif
        if (frame_sync_in) begin
          start_next    = 1'b1;
          mask_cnt_next = MASK_INIT;
          state_next    = S_MASK;
        end
      end
      S_MASK: begin
        // life_logic may still show done from the previous generation here.
        if (frame_sync_in) skip_next = sat_inc(skip_q);
        if (mask_cnt_q == '0) state_next = S_RUN;
        else mask_cnt_next = mask_cnt_q - MASK_W'(1);
      end
      S_RUN: begin
        // A sync coincident with done is still a miss; the swap waits.
        if (frame_sync_in) skip_next = sat_inc(skip_q);
        if (logic_done_in) state_next = S_READY;
      end
      S_READY: begin
        if (frame_sync_in) begin
          bank_sel_next = ~bank_sel_q;
          start_next    = 1'b1;
          mask_cnt_next = MASK_INIT;
          state_next    = S_MASK;
        end
      end
`ifdef LIFE_DB_CLEAR_EN
      S_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) state_next = S_IDLE;
        else clr_addr_next = clr_addr_q + LOG_MAX_ADDR'(1);
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Write path: life_logic writes land in the back bank (~bank_sel)
  // ---------------------------------------------------------------------
  always_comb begin
    wr0_en  = 1'b0;
    wr1_en  = 1'b0;
    wr_addr = logic_addr_w_in;
    wr_data = logic_data_w_in;
`ifdef LIFE_DB_CLEAR_EN
    if (state_q == S_CLEAR) begin
      wr0_en  = 1'b1;
      wr1_en  = 1'b1;
      wr_addr = clr_addr_q;
      wr_data = '0;
    end else
`endif
    begin
      wr0_en = logic_wr_en_in & bank_sel_q;
      wr1_en = logic_wr_en_in & ~bank_sel_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr0_en) bank0[wr_addr] <= wr_data;
    if (wr1_en) bank1[wr_addr] <= wr_data;
  end

  // ---------------------------------------------------------------------
  // Read path: address register, array read, output register (2 cycles)
  // ---------------------------------------------------------------------
`ifdef LIFE_DB_CLEAR_EN
  assign rd_zero = (state_q == S_CLEAR);
`else
  assign rd_zero = 1'b0;
`endif

  assign logic_rd_word = bank_sel_q ? bank1[logic_addr_q] : bank0[logic_addr_q];
  assign disp_rd_word  = bank_sel_q ? bank1[disp_addr_q]  : bank0[disp_addr_q];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      logic_addr_q     <= '0;
      disp_addr_q      <= '0;
      logic_data_r_out <= '0;
      disp_data_out    <= '0;
    end else begin
      logic_addr_q     <= logic_addr_r_in;
      disp_addr_q      <= disp_addr_in;
      logic_data_r_out <= rd_zero ? '0 : logic_rd_word;
      disp_data_out    <= rd_zero ? '0 : disp_rd_word;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign logic_start_out = start_q;
  assign bank_sel_out    = bank_sel_q;
  assign frame_skip_out  = skip_q;

`ifdef LIFE_DB_CLEAR_EN
  assign busy_out = (state_q == S_CLEAR);
`else
  assign busy_out = 1'b0;
`endif

endmodule

// File: tb/tb_life_double_buffer.sv
// tb/tb_life_double_buffer.sv - directed vector bench for life_double_buffer

module tb_life_double_buffer;

  logic        clk_in;
  logic        rst_n_in;
  logic        frame_sync_in;
  logic [11:0] logic_addr_r_in;
  logic [15:0] logic_data_r_out;
  logic [11:0] logic_addr_w_in;
  logic [15:0] logic_data_w_in;
  logic        logic_wr_en_in;
  logic        logic_done_in;
  logic        logic_start_out;
  logic [11:0] disp_addr_in;
  logic [15:0] disp_data_out;
  logic        bank_sel_out;
  logic [7:0]  frame_skip_out;
  logic        busy_out;

  int errors;
  int checks;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t wtab [6];
  vec_t wtab2 [3];

  life_double_buffer dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .frame_sync_in    (frame_sync_in),
    .logic_addr_r_in  (logic_addr_r_in),
    .logic_data_r_out (logic_data_r_out),
    .logic_addr_w_in  (logic_addr_w_in),
    .logic_data_w_in  (logic_data_w_in),
    .logic_wr_en_in   (logic_wr_en_in),
    .logic_done_in    (logic_done_in),
    .logic_start_out  (logic_start_out),
    .disp_addr_in     (disp_addr_in),
    .disp_data_out    (disp_data_out),
    .bank_sel_out     (bank_sel_out),
    .frame_skip_out   (frame_skip_out),
    .busy_out         (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sync_pulse();
    frame_sync_in = 1'b1;
    tick();
    frame_sync_in = 1'b0;
  endtask

  // From the first MASK cycle to the first RUN cycle.
  task automatic run_mask();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic finish_gen();
    logic_done_in = 1'b1;
    tick();
    logic_done_in = 1'b0;
  endtask

  task automatic write_word(input logic [11:0] a, input logic [15:0] d);
    logic_addr_w_in = a;
    logic_data_w_in = d;
    logic_wr_en_in  = 1'b1;
    tick();
    logic_wr_en_in  = 1'b0;
  endtask

  task automatic read_both(input string nm, input logic [11:0] a, input logic [15:0] exp);
    logic_addr_r_in = a;
    disp_addr_in    = a;
    tick();
    tick();
    chk({nm, "_logic"}, 32'(logic_data_r_out), 32'(exp));
    chk({nm, "_disp"}, 32'(disp_data_out), 32'(exp));
  endtask

  task automatic wait_clear();
`ifdef LIFE_DB_CLEAR_EN
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    tick();
    while (busy_out && n < 5000) begin
      if (logic_start_out) seen = 1'b1;
      frame_sync_in = (n == 100);
      if (n == 200) chk("clear_rd_zero", 32'(disp_data_out), 32'h0);
      n++;
      tick();
    end
    frame_sync_in = 1'b0;
    if (logic_start_out) seen = 1'b1;
    tick();
    if (logic_start_out) seen = 1'b1;
    chk("clear_busy_len", 32'(n), 32'd4096);
    chk("clear_no_start", 32'(seen), 32'h0);
    chk("clear_no_skip", 32'(frame_skip_out), 32'h0);
    read_both("clear_zero_5", 12'd5, 16'h0000);
    read_both("clear_zero_4095", 12'd4095, 16'h0000);
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_idle", 32'(busy_out), 32'h0);
    end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;

    wtab[0] = '{12'd4095, 16'h0001};
    wtab[1] = '{12'd0,    16'h0002};
    wtab[2] = '{12'd1,    16'h0003};
    wtab[3] = '{12'd5,    16'hA5A5};
    wtab[4] = '{12'd7,    16'h1234};
    wtab[5] = '{12'd2048, 16'hBEEF};
    wtab2[0] = '{12'd4095, 16'h1111};
    wtab2[1] = '{12'd0,    16'h2222};
    wtab2[2] = '{12'd1,    16'h3333};

    rst_n_in        = 1'b1;
    frame_sync_in   = 1'b0;
    logic_addr_r_in = '0;
    logic_addr_w_in = '0;
    logic_data_w_in = '0;
    logic_wr_en_in  = 1'b0;
    logic_done_in   = 1'b0;
    disp_addr_in    = '0;
    #2 rst_n_in = 1'b0;
    tick();
    tick();
    chk("rst_bank", 32'(bank_sel_out), 32'h0);
    chk("rst_start", 32'(logic_start_out), 32'h0);
    chk("rst_skip", 32'(frame_skip_out), 32'h0);
    chk("rst_busy", 32'(busy_out), 32'h0);
    chk("rst_rdata", 32'(logic_data_r_out), 32'h0);
    chk("rst_ddata", 32'(disp_data_out), 32'h0);
    rst_n_in = 1'b1;
    wait_clear();

    // Generation 1: done held through the mask window must be ignored.
    sync_pulse();
    chk("gen1_start", 32'(logic_start_out), 32'h1);
    chk("gen1_bank", 32'(bank_sel_out), 32'h0);
    logic_done_in = 1'b1;
    tick();
    chk("gen1_start_single", 32'(logic_start_out), 32'h0);
    tick();
    tick();
    tick();
    logic_done_in = 1'b0;
    for (int i = 0; i < 6; i++) write_word(wtab[i].addr, wtab[i].data);
    sync_pulse();
    chk("mask_done_ignored_bank", 32'(bank_sel_out), 32'h0);
    chk("run_sync_no_start", 32'(logic_start_out), 32'h0);
    chk("run_sync_skip", 32'(frame_skip_out), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    finish_gen();
    write_word(12'd9, 16'h0909);
    for (int i = 0; i < 20; i++) tick();
    chk("ready_hold_bank", 32'(bank_sel_out), 32'h0);
    sync_pulse();
    chk("swap1_bank", 32'(bank_sel_out), 32'h1);
    chk("swap1_start", 32'(logic_start_out), 32'h1);
    tick();
    chk("swap1_start_single", 32'(logic_start_out), 32'h0);

    for (int i = 0; i < 6; i++) read_both($sformatf("rd_tab%0d", i), wtab[i].addr, wtab[i].data);
    read_both("rd_ready_write", 12'd9, 16'h0909);

    // Latency: new address seen only on the second cycle.
    logic_addr_r_in = 12'd7;
    disp_addr_in    = 12'd7;
    tick();
    tick();
    logic_addr_r_in = 12'd5;
    disp_addr_in    = 12'd5;
    tick();
    chk("lat_cycle1_logic", 32'(logic_data_r_out), 32'h1234);
    chk("lat_cycle1_disp", 32'(disp_data_out), 32'h1234);
    tick();
    chk("lat_cycle2_logic", 32'(logic_data_r_out), 32'hA5A5);
    chk("lat_cycle2_disp", 32'(disp_data_out), 32'hA5A5);

    // Generation 2 writes bank 0; three syncs in RUN are skips.
    for (int i = 0; i < 3; i++) write_word(wtab2[i].addr, wtab2[i].data);
    for (int i = 0; i < 3; i++) begin
      sync_pulse();
      tick();
    end
    chk("overrun3_skip", 32'(frame_skip_out), 32'd4);
    chk("overrun3_bank", 32'(bank_sel_out), 32'h1);
    finish_gen();
    sync_pulse();
    chk("swap2_bank", 32'(bank_sel_out), 32'h0);
    chk("swap2_start", 32'(logic_start_out), 32'h1);
    for (int i = 0; i < 3; i++) read_both($sformatf("rd_tab2_%0d", i), wtab2[i].addr, wtab2[i].data);

    // Generation 3: swap back; bank 1 must still hold generation-1 data.
    finish_gen();
    sync_pulse();
    chk("swap3_bank", 32'(bank_sel_out), 32'h1);
    for (int i = 0; i < 3; i++) read_both($sformatf("rd_keep%0d", i), wtab[i].addr, wtab[i].data);

    // Sync coincident with done in RUN: READY only, skip counted.
    run_mask();
    frame_sync_in = 1'b1;
    logic_done_in = 1'b1;
    tick();
    frame_sync_in = 1'b0;
    logic_done_in = 1'b0;
    chk("sync_done_skip", 32'(frame_skip_out), 32'd5);
    chk("sync_done_bank", 32'(bank_sel_out), 32'h1);
    chk("sync_done_start", 32'(logic_start_out), 32'h0);
    tick();
    tick();
    sync_pulse();
    chk("sync_done_swap_bank", 32'(bank_sel_out), 32'h0);
    chk("sync_done_swap_start", 32'(logic_start_out), 32'h1);

    // Saturation.
    run_mask();
    for (int i = 0; i < 300; i++) begin
      sync_pulse();
      tick();
    end
    chk("skip_saturate", 32'(frame_skip_out), 32'd255);
    chk("skip_saturate_bank", 32'(bank_sel_out), 32'h0);

    // Async reset in RUN with bank 1 in front.
    finish_gen();
    sync_pulse();
    chk("pre_reset_bank", 32'(bank_sel_out), 32'h1);
    run_mask();
    logic_addr_r_in = 12'd4095;
    disp_addr_in    = 12'd0;
    tick();
    tick();
    chk("pre_reset_rdata", 32'(logic_data_r_out), 32'h0001);
    chk("pre_reset_ddata", 32'(disp_data_out), 32'h0002);
    @(posedge clk_in);
    #3 rst_n_in = 1'b0;
    #1;
    chk("async_rst_bank", 32'(bank_sel_out), 32'h0);
    chk("async_rst_start", 32'(logic_start_out), 32'h0);
    chk("async_rst_skip", 32'(frame_skip_out), 32'h0);
    chk("async_rst_rdata", 32'(logic_data_r_out), 32'h0);
    chk("async_rst_ddata", 32'(disp_data_out), 32'h0);
    chk("async_rst_busy", 32'(busy_out), 32'h0);
    tick();
    rst_n_in = 1'b1;
    wait_clear();
    sync_pulse();
    chk("restart_start", 32'(logic_start_out), 32'h1);
    chk("restart_bank", 32'(bank_sel_out), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
